// File: rtl/vending_machine_param.sv
// Parameterised coin-operated vending controller: accumulates 1/2/5-unit coins,
// vends at PRICE with registered change, supports cancel/refund and counts sales.
module vending_machine_param #(
   parameter int unsigned PRICE = 6,
   parameter int unsigned CW    = 4,
   parameter int unsigned SW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          one,
   input  logic          two,
   input  logic          five,
   input  logic          cancel,
   output logic          d,
   output logic [CW-1:0] r,
   output logic [CW-1:0] credit,
   output logic [SW-1:0] sales,
   output logic [1:0]    cs,
   output logic [1:0]    ns
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      VEND   = 2'd2,
      REFUND = 2'd3
   } state_e;

   localparam logic [CW-1:0] PRICE_W = CW'(PRICE);

   state_e        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic [CW-1:0] r_q, r_d;
   logic          d_q, d_d;
   logic [SW-1:0] sales_q, sales_d;
   logic          coin_valid;
   logic [CW-1:0] coin_val;
   logic [CW-1:0] sum;

   // Exactly one coin line high is a valid coin; anything else is ignored.
   always_comb begin
      coin_valid = 1'b0;
      coin_val   = '0;
      unique case ({one, two, five})
         3'b100: begin coin_valid = 1'b1; coin_val = CW'(1); end
         3'b010: begin coin_valid = 1'b1; coin_val = CW'(2); end
         3'b001: begin coin_valid = 1'b1; coin_val = CW'(5); end
         default: begin coin_valid = 1'b0; coin_val = '0; end
      endcase
   end

   assign sum = credit_q + coin_val;

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      sales_d  = sales_q;
      d_d      = 1'b0;
      r_d      = '0;
      unique case (state_q)
         IDLE, ACCUM: begin
            // Cancel wins over a coin, but only once credit is being held.
            if (state_q == ACCUM && cancel) begin
               state_d = REFUND;
            end else if (coin_valid) begin
               if (sum < PRICE_W) begin
                  credit_d = sum;
                  state_d  = ACCUM;
               end else begin
                  credit_d = sum - PRICE_W;
                  state_d  = VEND;
               end
            end
         end
         VEND: begin
            state_d  = IDLE;
            credit_d = '0;
            sales_d  = sales_q + SW'(1);
         end
         REFUND: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase
      // Outputs are registered from the upcoming state so they align with cs.
      d_d = (state_d == VEND);
      if (state_d == VEND || state_d == REFUND) begin
         r_d = credit_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         credit_q <= '0;
         sales_q  <= '0;
         d_q      <= 1'b0;
         r_q      <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         sales_q  <= sales_d;
         d_q      <= d_d;
         r_q      <= r_d;
      end
   end

   assign d      = d_q;
   assign r      = r_q;
   assign credit = credit_q;
   assign sales  = sales_q;
   assign cs     = state_q;
   assign ns     = state_d;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param; a second instance with SW=2 shares
// the stimulus so sales wrap-around can be observed alongside the default build.
module tb_vending_machine_param;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       one = 1'b0, two = 1'b0, five = 1'b0, cancel = 1'b0;
   logic       d, d2;
   logic [3:0] r, credit, r2, credit2;
   logic [7:0] sales;
   logic [1:0] sales2;
   logic [1:0] cs, ns, cs2, ns2;

   int n_pass  = 0;
   int n_total = 0;

   vending_machine_param #(.PRICE(6), .CW(4), .SW(8)) dut (
      .clk(clk), .reset(reset), .one(one), .two(two), .five(five), .cancel(cancel),
      .d(d), .r(r), .credit(credit), .sales(sales), .cs(cs), .ns(ns)
   );

   vending_machine_param #(.PRICE(6), .CW(4), .SW(2)) dut2 (
      .clk(clk), .reset(reset), .one(one), .two(two), .five(five), .cancel(cancel),
      .d(d2), .r(r2), .credit(credit2), .sales(sales2), .cs(cs2), .ns(ns2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic drive(input logic o, input logic t, input logic f, input logic c);
      one = o; two = t; five = f; cancel = c;
   endtask

   // One clock: sample after the edge, then release the coin/cancel lines.
   task automatic tick();
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic st(input string tag, input logic [1:0] e_cs, input logic [3:0] e_cr,
                     input logic e_d, input logic [3:0] e_r, input logic [7:0] e_s);
      logic [1:0] e_s2;
      e_s2 = e_s[1:0];
      chk({tag, ".cs"},     32'(cs),     32'(e_cs));
      chk({tag, ".credit"}, 32'(credit), 32'(e_cr));
      chk({tag, ".d"},      32'(d),      32'(e_d));
      chk({tag, ".r"},      32'(r),      32'(e_r));
      chk({tag, ".sales"},  32'(sales),  32'(e_s));
      chk({tag, ".sales2"}, 32'(sales2), 32'(e_s2));
   endtask

   initial begin
      // Asynchronous reset takes effect without a clock edge.
      #1 reset = 1'b1;
      #1 st("reset_async", 2'd0, 4'd0, 1'b0, 4'd0, 8'd0);
      @(posedge clk); #1 reset = 1'b0;
      tick();
      st("after_reset", 2'd0, 4'd0, 1'b0, 4'd0, 8'd0);

      // Six single 1-unit coins with idle gaps.
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         #1 chk("one_ns", 32'(ns), 32'd1);
         tick();
         st("one_acc", 2'd1, 4'(i), 1'b0, 4'd0, 8'd0);
         tick();
         chk("one_idlegap_credit", 32'(credit), 32'(i));
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      st("one_vend", 2'd2, 4'd0, 1'b1, 4'd0, 8'd0);
      chk("one_vend_ns", 32'(ns), 32'd0);
      tick();
      st("one_done", 2'd0, 4'd0, 1'b0, 4'd0, 8'd1);

      // Three 2-unit coins.
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick(); st("two_1", 2'd1, 4'd2, 1'b0, 4'd0, 8'd1);
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick(); st("two_2", 2'd1, 4'd4, 1'b0, 4'd0, 8'd1);
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick(); st("two_vend", 2'd2, 4'd0, 1'b1, 4'd0, 8'd1);
      tick(); st("two_done", 2'd0, 4'd0, 1'b0, 4'd0, 8'd2);

      // Back-to-back: coin right after VEND; five+two gives change 1, coin in VEND ignored.
      drive(1'b0, 1'b0, 1'b1, 1'b0); tick(); st("f2_5", 2'd1, 4'd5, 1'b0, 4'd0, 8'd2);
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick(); st("f2_vend", 2'd2, 4'd1, 1'b1, 4'd1, 8'd2);
      drive(1'b0, 1'b0, 1'b1, 1'b0); tick(); st("coin_in_vend", 2'd0, 4'd0, 1'b0, 4'd0, 8'd3);

      // Five, five gives maximum change of 4.
      drive(1'b0, 1'b0, 1'b1, 1'b0); tick(); st("ff_5", 2'd1, 4'd5, 1'b0, 4'd0, 8'd3);
      drive(1'b0, 1'b0, 1'b1, 1'b0); tick(); st("ff_vend", 2'd2, 4'd4, 1'b1, 4'd4, 8'd3);
      tick(); st("ff_done", 2'd0, 4'd0, 1'b0, 4'd0, 8'd4);

      // Three ones then cancel: refund 3, sales unchanged.
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
      end
      st("c_acc3", 2'd1, 4'd3, 1'b0, 4'd0, 8'd4);
      drive(1'b0, 1'b0, 1'b0, 1'b1); tick();
      st("c_refund", 2'd3, 4'd3, 1'b0, 4'd3, 8'd4);
      chk("c_refund_ns", 32'(ns), 32'd0);
      tick(); st("c_done", 2'd0, 4'd0, 1'b0, 4'd0, 8'd4);

      // Cancel alone in IDLE and an invalid coin in IDLE are ignored.
      drive(1'b0, 1'b0, 1'b0, 1'b1); tick(); st("cancel_idle", 2'd0, 4'd0, 1'b0, 4'd0, 8'd4);
      drive(1'b1, 1'b0, 1'b1, 1'b0); tick(); st("invalid_idle", 2'd0, 4'd0, 1'b0, 4'd0, 8'd4);

      // Invalid combo in ACCUM, then cancel beats a simultaneous coin.
      drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); st("m_acc1", 2'd1, 4'd1, 1'b0, 4'd0, 8'd4);
      drive(1'b1, 1'b1, 1'b0, 1'b0); tick(); st("m_invalid", 2'd1, 4'd1, 1'b0, 4'd0, 8'd4);
      drive(1'b0, 1'b1, 1'b0, 1'b1); tick(); st("m_cancel_coin", 2'd3, 4'd1, 1'b0, 4'd1, 8'd4);
      tick(); st("m_done", 2'd0, 4'd0, 1'b0, 4'd0, 8'd4);

      // Coin with cancel in IDLE is a normal coin.
      drive(1'b0, 1'b1, 1'b0, 1'b1); tick(); st("idle_coin_cancel", 2'd1, 4'd2, 1'b0, 4'd0, 8'd4);
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick(); st("pre_reset", 2'd1, 4'd4, 1'b0, 4'd0, 8'd4);

      // Reset mid-period with credit 4: cleared before the next edge.
      #2 reset = 1'b1;
      #1 st("reset_mid", 2'd0, 4'd0, 1'b0, 4'd0, 8'd0);
      @(posedge clk); #1 reset = 1'b0;
      tick(); st("reset_resume", 2'd0, 4'd0, 1'b0, 4'd0, 8'd0);

      // Reset during VEND: no sales increment.
      drive(1'b0, 1'b0, 1'b1, 1'b0); tick(); st("rv_5", 2'd1, 4'd5, 1'b0, 4'd0, 8'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); st("rv_vend", 2'd2, 4'd0, 1'b1, 4'd0, 8'd0);
      #2 reset = 1'b1;
      #1 st("rv_reset", 2'd0, 4'd0, 1'b0, 4'd0, 8'd0);
      @(posedge clk); #1 reset = 1'b0;
      tick(); st("rv_after", 2'd0, 4'd0, 1'b0, 4'd0, 8'd0);

      // Five vends: sales2 (SW=2) wraps 1,2,3,0,1.
      for (int k = 1; k <= 5; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
         drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
         st("wrap_vend", 2'd2, 4'd0, 1'b1, 4'd0, 8'(k - 1));
         tick();
         st("wrap_done", 2'd0, 4'd0, 1'b0, 4'd0, 8'(k));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vending_machine_param.md
VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL provide parameter PRICE, default 6, item price in credit units; legal range 1..(2^CW)-5.
REQ-002 SHALL provide parameter CW, default 4, width of the credit and change datapaths.
REQ-003 SHALL provide parameter SW, default 8, width of the sales counter.
REQ-004 SHALL provide port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port one  input  1  1-unit coin inserted; level held for one clock.
REQ-007 SHALL provide port two  input  1  2-unit coin inserted; level held for one clock.
REQ-008 SHALL provide port five  input  1  5-unit coin inserted; level held for one clock.
REQ-009 SHALL provide port cancel  input  1  customer refund request.
REQ-010 SHALL provide port d  output  1  dispense pulse.
REQ-011 SHALL provide port r  output  CW  change or refund amount; valid only while d=1 or cs=REFUND.
REQ-012 SHALL provide port credit  output  CW  current accumulated credit.
REQ-013 SHALL provide port sales  output  SW  count of completed vends.
REQ-014 SHALL provide port cs  output  2  current state encoding.
REQ-015 SHALL provide port ns  output  2  next state encoding, combinational.

Function
REQ-016 SHALL encode states IDLE=0, ACCUM=1, VEND=2, REFUND=3.
REQ-017 SHALL, for a valid coin, sample exactly one of one/two/five high; value = 1/2/5 respectively.
REQ-018 SHALL treat any coin combination with more than one line high as invalid: no credit change, no state change.
REQ-019 SHALL accept coins only in IDLE and ACCUM; coins in VEND or REFUND are ignored, with no credit effect.
REQ-020 SHALL, on a valid coin in IDLE/ACCUM, compute sum = credit + coin at full CW width; overflow is impossible by the PRICE range.
REQ-021 SHALL, if sum < PRICE, load credit <= sum and go to ACCUM.
REQ-022 SHALL, if sum >= PRICE, load credit <= sum - PRICE and go to VEND.
REQ-023 SHALL, in VEND, drive d=1 and r=credit (change, 0..4) for exactly one cycle, then go to IDLE with credit <= 0.
REQ-024 SHALL increment sales by 1 on each VEND exit, wrapping modulo 2^SW without saturation.
REQ-025 SHALL, on cancel=1 in ACCUM, go to REFUND while credit holds its value.
REQ-026 SHALL, in REFUND, drive d=0 and r=credit for one cycle, then go to IDLE with credit <= 0.
REQ-027 SHALL ignore cancel in IDLE, VEND and REFUND.
REQ-028 SHALL give cancel priority over a simultaneous coin in ACCUM; the coin is not credited.
REQ-029 SHALL treat a coin with cancel in IDLE as a normal coin, because cancel is ignored in IDLE.
REQ-030 SHALL drive r=0 in IDLE and ACCUM, and d=0 in every state except VEND.
REQ-031 SHALL register d, r, credit, sales and cs as state outputs, with no combinational path from any input to them.
REQ-032 SHALL advance at most one state per clock, allowing back-to-back vends: a coin in the cycle after VEND is accepted in IDLE.

Reset
REQ-033 SHALL, while reset=1, force cs=IDLE, credit=0, sales=0, d=0 and r=0 immediately, independent of clk.
REQ-034 SHALL discard accumulated credit on reset mid-transaction, with no refund pulse.
REQ-035 SHALL discard any vend in progress on reset asserted during VEND, with no sales increment.
REQ-036 SHALL resume operation from IDLE on the first rising edge after reset deasserts.

Verification (PRICE=6, CW=4 unless stated)
REQ-037 SHALL cover: six single `one` pulses separated by idle cycles -> credit 1..5, then one VEND cycle with d=1, r=0, sales=1.
REQ-038 SHALL cover: three `two` pulses -> VEND with r=0; then five followed by two -> VEND with r=1; then five, five -> VEND with r=4.
REQ-039 SHALL cover: one x3 then cancel -> REFUND with r=3, d=0, then IDLE with credit=0 and sales unchanged.
REQ-040 SHALL cover: one and two high together, then two with cancel together in ACCUM -> no credit change for the first, REFUND with the prior credit for the second.
REQ-041 SHALL cover: reset asserted mid-clock-period with credit=4 -> credit=0 and cs=0 before the next edge, with no r pulse.
REQ-042 SHALL cover: SW=2 with five vends -> sales reads 1,2,3,0,1.
